// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster-scan controller for the 64x32 cell video RAM.
// Divides clk into a pixel tick and runs the horizontal and vertical counters.
// Tracks which cell is being scanned without using a divider, and reads the
// cell's colour from RAM through a two-tick pipeline that keeps rgb aligned
// with hsync and vsync.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   addr_read    video RAM read address {cell_row[4:0], cell_col[5:0]}
//   ram_dout     video RAM read data, valid one clk after addr_read
//   rgb          pixel colour {r,g,b}, 0 during blanking
//   hsync/vsync  active-low sync outputs
//   frame_start  one-clk pulse when the scan wraps back to (0,0)
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 10,
  parameter int CELL_H   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] addr_read,
  input  logic [2:0]  ram_dout,
  output logic [2:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = $clog2(CLK_DIV);
  localparam int CSW = $clog2(CELL_W + 1);
  localparam int RSW = $clog2(CELL_H + 1);

  localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0]  HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]  VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CSW-1:0] COL_LAST   = CSW'(CELL_W - 1);
  localparam logic [RSW-1:0] ROW_LAST   = RSW'(CELL_H - 1);

  logic [DW-1:0]  div;
  logic           tick;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [CSW-1:0] col_sub;
  logic [RSW-1:0] row_sub;
  logic [5:0]     cell_col;
  logic [4:0]     cell_row;
  logic           h_last, v_last, h_act, v_act;
  logic           blank1, hs1, vs1;

  assign tick   = (div == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign h_act  = (h_cnt < H_ACT);
  assign v_act  = (v_cnt < V_ACT);

  // Pixel tick divider: first tick lands CLK_DIV clks after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + DW'(1);
  end

  // Raster counters and cell tracking.  The last cell column/row is held
  // (no increment on the final active pixel/line) so the 6/5-bit cell
  // counters only return to 0 through the wrap clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      col_sub  <= '0;
      row_sub  <= '0;
      cell_col <= '0;
      cell_row <= '0;
    end else if (tick) begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);

      if (h_last) begin
        col_sub  <= '0;
        cell_col <= '0;
      end else if (h_act) begin
        if (col_sub == COL_LAST) begin
          col_sub <= '0;
          if (h_cnt != H_ACT_LAST) cell_col <= cell_col + 6'd1;
        end else begin
          col_sub <= col_sub + CSW'(1);
        end
      end

      if (h_last) begin
        if (v_last) begin
          row_sub  <= '0;
          cell_row <= '0;
        end else if (v_act) begin
          if (row_sub == ROW_LAST) begin
            row_sub <= '0;
            if (v_cnt != V_ACT_LAST) cell_row <= cell_row + 5'd1;
          end else begin
            row_sub <= row_sub + RSW'(1);
          end
        end
      end
    end
  end

  // Two-stage output pipeline, advanced on tick only.  Stage 1 issues the
  // RAM address (held through blanking); stage 2 samples ram_dout, which
  // has had at least one clk to settle since addr_read changed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_read <= '0;
      blank1    <= 1'b1;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      rgb       <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (tick) begin
      if (h_act && v_act) addr_read <= {cell_row, cell_col};
      blank1 <= !(h_act && v_act);
      hs1    <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs1    <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      rgb    <= blank1 ? 3'd0 : ram_dout;
      hsync  <= hs1;
      vsync  <= vs1;
    end
  end

  // Pulse on the clk following the tick that wraps (H_TOTAL-1, V_TOTAL-1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= tick && h_last && v_last;
  end

endmodule
